// File: rtl/div_unit_pkg.sv
// Shared divider definitions: default width, FSM state encoding and the
// DIV/DIVU function-field encodings used by the decoder.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam logic [5:0] FUNCT_DIV  = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU = 6'h1b;

    function automatic logic funct_is_div(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

    function automatic logic funct_is_signed(input logic [5:0] funct);
        return funct == FUNCT_DIV;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divider bundle: request/operands from the pipe, stall and HI/LO
// result back to the pipe.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] opdata1;
    logic [WIDTH-1:0] opdata2;
    logic             annul;
    logic             div_stall;
    logic             result_valid;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output div_start, div_signed, opdata1, opdata2, annul,
        input  div_stall, result_valid, hi_out, lo_out
    );

    modport slave (
        input  div_start, div_signed, opdata1, opdata2, annul,
        output div_stall, result_valid, hi_out, lo_out
    );
endinterface

// File: rtl/div_unit_step.sv
// One restoring shift-subtract step: shifts {rem,quo} left and keeps the
// trial difference whenever the shifted remainder covers the divisor.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   trial;
    logic             keep;

    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign keep    = shifted >= {2'b00, divisor_in};
    assign trial   = shifted[WIDTH:0] - {1'b0, divisor_in};
    assign rem_out = keep ? trial : shifted[WIDTH:0];
    assign quo_out = {quo_in[WIDTH-2:0], keep};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; stalls the pipe while
// busy and presents quotient on LO, remainder on HI for one cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic       clk,
    input logic       resetn,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             neg_quo_reg;
    logic             neg_rem_reg;
    logic             result_valid_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic [WIDTH-1:0] abs_op1;
    logic [WIDTH-1:0] abs_op2;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    // Magnitudes of the operands; 0x80000000 maps onto itself, which the
    // unsigned core handles correctly.
    assign abs_op1 = (bus.div_signed && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
    assign abs_op2 = (bus.div_signed && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem_in     (rem_reg),
        .quo_in     (quo_reg),
        .divisor_in (divisor_reg),
        .rem_out    (step_rem),
        .quo_out    (step_quo)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= ST_IDLE;
            count_reg        <= '0;
            rem_reg          <= '0;
            quo_reg          <= '0;
            divisor_reg      <= '0;
            neg_quo_reg      <= 1'b0;
            neg_rem_reg      <= 1'b0;
            result_valid_reg <= 1'b0;
            hi_reg           <= '0;
            lo_reg           <= '0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.div_start && !bus.annul) begin
                        rem_reg     <= '0;
                        quo_reg     <= abs_op1;
                        divisor_reg <= abs_op2;
                        neg_quo_reg <= bus.div_signed & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                        neg_rem_reg <= bus.div_signed & bus.opdata1[WIDTH-1];
                        count_reg   <= '0;
                        state_reg   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.annul) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        rem_reg   <= step_rem;
                        quo_reg   <= step_quo;
                        count_reg <= count_reg + 1'b1;
                        // Last step: fix up signs straight from the step output.
                        if (count_reg == CNT_W'(WIDTH - 1)) begin
                            lo_reg           <= neg_quo_reg ? -step_quo : step_quo;
                            hi_reg           <= neg_rem_reg ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
                            result_valid_reg <= 1'b1;
                            state_reg        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.div_stall    = ~bus.annul & (((state_reg == ST_IDLE) & bus.div_start) | (state_reg == ST_BUSY));
    assign bus.result_valid = result_valid_reg;
    assign bus.hi_out       = hi_reg;
    assign bus.lo_out       = lo_reg;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus hand-written sequences
// for back-to-back, annul, operand change and mid-divide reset.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_hi;
    } vec_t;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } res_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) bus();

    div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    res_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one divide from the current cycle and waits for result_valid.
    task automatic do_div(input logic [5:0] funct, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                          input int exp_lat, input bit scramble);
        res_t r;
        int   cyc;
        bit   stall_ok;
        bit   got;
        bus.div_start  = 1'b1;
        bus.div_signed = funct_is_signed(funct);
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.annul      = 1'b0;
        r.lo = exp_lo;
        r.hi = exp_hi;
        sb_q.push_back(r);
        stall_ok = 1'b1;
        got      = 1'b0;
        cyc      = 0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.result_valid === 1'b1) got = 1'b1;
            else if (bus.div_stall !== 1'b1) stall_ok = 1'b0;
            if (scramble && cyc == 5) begin
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.div_signed = ~bus.div_signed;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL timeout: no result_valid after %0d cycles, required 1", cyc);
            void'(sb_q.pop_front());
        end else begin
            check("latency", cyc, exp_lat);
            check("stall_held", {31'd0, stall_ok}, 32'd1);
            check("stall_in_done", {31'd0, bus.div_stall}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard: result with empty queue, got lo=0x%08h", bus.lo_out);
            end else begin
                r = sb_q.pop_front();
                check("lo", bus.lo_out, r.lo);
                check("hi", bus.hi_out, r.hi);
            end
            $display("div %s a=0x%08h b=0x%08h lo=0x%08h hi=0x%08h cycles=%0d",
                     funct_is_signed(funct) ? "DIV " : "DIVU", a, b, bus.lo_out, bus.hi_out, cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[11];
        logic [W-1:0] ra, rb, rq, rr;
        logic [5:0]   rf;
        bit           seen_valid;

        vecs[0]  = '{FUNCT_DIVU, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{FUNCT_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2]  = '{FUNCT_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[3]  = '{FUNCT_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
        vecs[4]  = '{FUNCT_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vecs[5]  = '{FUNCT_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF};
        vecs[6]  = '{FUNCT_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
        vecs[7]  = '{FUNCT_DIVU, 32'd3,          32'd10,         32'd0,          32'd3};
        vecs[8]  = '{FUNCT_DIV,  32'hFFFFFFFB,   32'd0,          32'd1,          32'hFFFFFFFB};
        vecs[9]  = '{FUNCT_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
        vecs[10] = '{FUNCT_DIVU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};

        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.annul      = 1'b0;
        resetn         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", {31'd0, bus.div_stall}, 32'd0);
        check("rst_valid", {31'd0, bus.result_valid}, 32'd0);
        check("rst_hi", bus.hi_out, 32'd0);
        check("rst_lo", bus.lo_out, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_div(vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].exp_lo, vecs[i].exp_hi, 33, 1'b0);
            bus.div_start = 1'b0;
            @(negedge clk);
        end

        // Random operands against the language's own division operators.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 0) rb = 32'd1;
            rf = ($urandom_range(0, 1) == 1) ? FUNCT_DIV : FUNCT_DIVU;
            if (rf == FUNCT_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
            if (rf == FUNCT_DIV) begin
                rq = $signed(ra) / $signed(rb);
                rr = $signed(ra) % $signed(rb);
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            do_div(rf, ra, rb, rq, rr, 33, 1'b0);
            bus.div_start = 1'b0;
            @(negedge clk);
        end

        // Operands changed mid-divide must be ignored.
        do_div(FUNCT_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);
        bus.div_start = 1'b0;
        @(negedge clk);

        // Back-to-back: second divide enters IDLE straight after DONE.
        do_div(FUNCT_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);
        do_div(FUNCT_DIVU, 32'd10, 32'd4, 32'd2, 32'd2, 34, 1'b0);
        bus.div_start = 1'b0;
        @(negedge clk);

        // Annul while BUSY with count==10.
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.opdata1    = 32'd100;
        bus.opdata2    = 32'd7;
        repeat (11) @(negedge clk);
        check("annul_busy_stall", {31'd0, bus.div_stall}, 32'd1);
        bus.annul = 1'b1;
        #1;
        check("annul_stall", {31'd0, bus.div_stall}, 32'd0);
        @(negedge clk);
        bus.annul     = 1'b0;
        bus.div_start = 1'b0;
        #1;
        check("annul_idle", {31'd0, bus.div_stall}, 32'd0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("annul_no_valid", {31'd0, seen_valid}, 32'd0);
        check("annul_lo_held", bus.lo_out, 32'd2);
        $display("annul at count=10: div_stall released, result_valid seen=%0d", seen_valid);

        // Asynchronous reset in the middle of a divide.
        bus.div_start = 1'b1;
        bus.opdata1   = 32'd100;
        bus.opdata2   = 32'd7;
        repeat (15) @(negedge clk);
        bus.div_start = 1'b0;
        resetn        = 1'b0;
        #1;
        check("midrst_stall", {31'd0, bus.div_stall}, 32'd0);
        check("midrst_valid", {31'd0, bus.result_valid}, 32'd0);
        check("midrst_hi", bus.hi_out, 32'd0);
        check("midrst_lo", bus.lo_out, 32'd0);
        $display("reset mid-BUSY: lo=0x%08h hi=0x%08h", bus.lo_out, bus.hi_out);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_div(FUNCT_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
        bus.div_start = 1'b0;
        @(negedge clk);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
